// File: rtl/seg7_reader.sv
// Purpose    : loopback monitor for a 7-segment counter display; debounces seg_in,
//              decodes accepted patterns to hex digits and rebuilds an 8-bit count.
// Latency    : outputs update STABLE_CYCLES+1 edges after a new value first reaches seg_in.
// Backpressure: none; the block samples seg_in every cycle and never stalls.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   seg_in[6:0]    segment lines, active-high, bit0=a .. bit6=g
//   digit_out[3:0] last accepted valid digit
//   digit_valid    a valid digit has been accepted since reset
//   step_pulse     one cycle: accepted digit == previous + 1 (mod 16)
//   count_out[7:0] reconstructed running count
//   invalid_pulse  one cycle: accepted pattern is not a hex glyph
//   skip_err       sticky: digit changed by something other than +1
//   invalid_err    sticky: an illegal pattern was accepted
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit_out,
    output logic       digit_valid,
    output logic       step_pulse,
    output logic [7:0] count_out,
    output logic       invalid_pulse,
    output logic       skip_err,
    output logic       invalid_err
);

    localparam logic [3:0] LP_STABLE = 4'(STABLE_CYCLES);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Returns {legal, digit}.
    function automatic logic [4:0] f_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h3F:   res = {1'b1, 4'h0};
            7'h06:   res = {1'b1, 4'h1};
            7'h5B:   res = {1'b1, 4'h2};
            7'h4F:   res = {1'b1, 4'h3};
            7'h66:   res = {1'b1, 4'h4};
            7'h6D:   res = {1'b1, 4'h5};
            7'h7D:   res = {1'b1, 4'h6};
            7'h07:   res = {1'b1, 4'h7};
            7'h7F:   res = {1'b1, 4'h8};
            7'h6F:   res = {1'b1, 4'h9};
            7'h77:   res = {1'b1, 4'hA};
            7'h7C:   res = {1'b1, 4'hB};
            7'h39:   res = {1'b1, 4'hC};
            7'h5E:   res = {1'b1, 4'hD};
            7'h79:   res = {1'b1, 4'hE};
            7'h71:   res = {1'b1, 4'hF};
            default: res = {1'b0, 4'h0};
        endcase
        return res;
    endfunction

    // ---------------- input stage / stability filter ----------------
    logic [6:0] r_s;
    logic [3:0] r_run;
    logic       r_acc;

    logic       w_restart;
    logic [3:0] w_run_next;
    logic       w_acc_evt;

    // r_run==0 only right after reset: the first post-reset capture always
    // opens a fresh run, so the reset value of r_s never counts.
    assign w_restart  = (r_run == 4'd0) || (seg_in != r_s);
    // Saturate at the threshold so the accept cannot re-fire while held.
    assign w_run_next = w_restart ? 4'd1 :
                        (r_run < LP_STABLE) ? r_run + 4'd1 : r_run;
    assign w_acc_evt  = (w_run_next == LP_STABLE) && (w_restart || (r_run != LP_STABLE));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s   <= 7'h00;
            r_run <= 4'd0;
            r_acc <= 1'b0;
        end else begin
            r_s   <= seg_in;
            r_run <= w_run_next;
            r_acc <= w_acc_evt;
        end
    end

    // r_acc is high the cycle after the accept edge; r_s still holds the
    // accepted pattern then, since it was stable (or just captured) at that edge.
    logic [4:0] w_dec;
    logic       w_dec_ok;
    logic [3:0] w_dec_d;
    assign w_dec    = f_decode(r_s);
    assign w_dec_ok = w_dec[4];
    assign w_dec_d  = w_dec[3:0];

    // ---------------- tracking FSM ----------------
    state_t     r_state, w_state_nxt;
    logic [3:0] r_digit, w_digit_nxt;
    logic [7:0] r_count, w_count_nxt;
    logic       r_step, w_step_nxt;
    logic       r_inv, w_inv_nxt;
    logic       r_skip, w_skip_nxt;
    logic       r_inv_err, w_inv_err_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_digit   <= 4'h0;
            r_count   <= 8'h00;
            r_step    <= 1'b0;
            r_inv     <= 1'b0;
            r_skip    <= 1'b0;
            r_inv_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_digit   <= w_digit_nxt;
            r_count   <= w_count_nxt;
            r_step    <= w_step_nxt;
            r_inv     <= w_inv_nxt;
            r_skip    <= w_skip_nxt;
            r_inv_err <= w_inv_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_digit_nxt   = r_digit;
        w_count_nxt   = r_count;
        w_step_nxt    = 1'b0;
        w_inv_nxt     = 1'b0;
        w_skip_nxt    = r_skip;
        w_inv_err_nxt = r_inv_err;
        if (r_acc) begin
            if (!w_dec_ok) begin
                // Illegal glyph: flag only, tracked digit and count untouched.
                w_inv_nxt     = 1'b1;
                w_inv_err_nxt = 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_digit_nxt = w_dec_d;
                        w_count_nxt = {4'h0, w_dec_d};
                        w_state_nxt = ST_TRACK;
                    end
                    ST_TRACK: begin
                        if (w_dec_d == r_digit) begin
                            // Same digit re-accepted after a glitch: nothing to do.
                            w_digit_nxt = r_digit;
                        end else if (w_dec_d == (r_digit + 4'd1)) begin
                            w_step_nxt  = 1'b1;
                            w_count_nxt = r_count + 8'd1;
                            w_digit_nxt = w_dec_d;
                        end else begin
                            w_skip_nxt  = 1'b1;
                            w_count_nxt = {r_count[7:4], w_dec_d};
                            w_digit_nxt = w_dec_d;
                        end
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    assign digit_out     = r_digit;
    assign digit_valid   = (r_state == ST_TRACK);
    assign step_pulse    = r_step;
    assign count_out     = r_count;
    assign invalid_pulse = r_inv;
    assign skip_err      = r_skip;
    assign invalid_err   = r_inv_err;

endmodule

// File: tb/tb_seg7_reader.sv
// Purpose    : self-checking bench for seg7_reader against a run-length reference model.
// Latency    : model applies an accept one edge after the run reaches STABLE_CYCLES.
// Backpressure: none.
module tb_seg7_reader;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] seg_in = 7'h00;
    logic [3:0] digit_out;
    logic       digit_valid;
    logic       step_pulse;
    logic [7:0] count_out;
    logic       invalid_pulse;
    logic       skip_err;
    logic       invalid_err;

    seg7_reader #(.STABLE_CYCLES(S)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .seg_in        (seg_in),
        .digit_out     (digit_out),
        .digit_valid   (digit_valid),
        .step_pulse    (step_pulse),
        .count_out     (count_out),
        .invalid_pulse (invalid_pulse),
        .skip_err      (skip_err),
        .invalid_err   (invalid_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model state
    int         m_digit, m_count, m_valid, m_step, m_inv, m_skip, m_inverr;
    int         m_len;
    logic [6:0] m_last;
    bit         m_pend;
    logic [6:0] m_pend_pat;
    int         m_step_cnt = 0, m_inv_cnt = 0, d_step_cnt = 0, d_inv_cnt = 0;

    function automatic int lookup(input logic [6:0] pat);
        for (int i = 0; i < 16; i++)
            if (tbl[i] == pat) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_digit = 0; m_count = 0; m_valid = 0; m_step = 0; m_inv = 0;
        m_skip = 0; m_inverr = 0; m_len = 0; m_last = 7'h00; m_pend = 0;
        m_pend_pat = 7'h00;
    endtask

    task automatic model_accept(input logic [6:0] pat);
        int d;
        d = lookup(pat);
        if (d < 0) begin
            m_inv = 1; m_inverr = 1;
        end else if (m_valid == 0) begin
            m_valid = 1; m_digit = d; m_count = d;
        end else if (d == m_digit) begin
            m_digit = d;
        end else if (d == (m_digit + 1) % 16) begin
            m_step = 1; m_count = (m_count + 1) % 256; m_digit = d;
        end else begin
            m_skip = 1; m_count = (m_count / 16) * 16 + d; m_digit = d;
        end
    endtask

    // Present one pattern for one edge; advance the model; tally pulses.
    task automatic drive_cycle(input logic [6:0] pat);
        seg_in = pat;
        @(posedge clk);
        #1;
        m_step = 0; m_inv = 0;
        if (m_pend) model_accept(m_pend_pat);
        m_pend = 0;
        if (m_len == 0 || pat != m_last) m_len = 1;
        else m_len = m_len + 1;
        m_last = pat;
        if (m_len == S) begin
            m_pend = 1; m_pend_pat = pat;
        end
        m_step_cnt += m_step; m_inv_cnt += m_inv;
        d_step_cnt += int'(step_pulse); d_inv_cnt += int'(invalid_pulse);
    endtask

    task automatic hold(input logic [6:0] pat, input int n);
        for (int i = 0; i < n; i++) drive_cycle(pat);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        seg_in = 7'($urandom);
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        checks += 7;
        if (digit_out !== 4'h0) begin errors++; $display("FAIL reset digit_out: got %0h want 0", digit_out); end
        if (digit_valid !== 1'b0) begin errors++; $display("FAIL reset digit_valid: got %0b want 0", digit_valid); end
        if (count_out !== 8'h00) begin errors++; $display("FAIL reset count_out: got %0h want 0", count_out); end
        if (step_pulse !== 1'b0) begin errors++; $display("FAIL reset step_pulse: got %0b want 0", step_pulse); end
        if (invalid_pulse !== 1'b0) begin errors++; $display("FAIL reset invalid_pulse: got %0b want 0", invalid_pulse); end
        if (skip_err !== 1'b0) begin errors++; $display("FAIL reset skip_err: got %0b want 0", skip_err); end
        if (invalid_err !== 1'b0) begin errors++; $display("FAIL reset invalid_err: got %0b want 0", invalid_err); end
    endtask

    task automatic test_stable_digit();
        hold(7'h3F, S);          // edges k .. k+S-1
        checks++;
        if (digit_valid !== 1'b0) begin errors++; $display("FAIL latency early digit_valid: got %0b want 0", digit_valid); end
        drive_cycle(7'h3F);      // edge k+S
        checks += 4;
        if (digit_valid !== 1'b1) begin errors++; $display("FAIL latency digit_valid: got %0b want 1", digit_valid); end
        if (digit_out !== 4'h0) begin errors++; $display("FAIL stable digit_out: got %0h want 0", digit_out); end
        if (count_out !== 8'h00) begin errors++; $display("FAIL stable count_out: got %0h want 0", count_out); end
        if ({step_pulse, invalid_pulse} !== 2'b00) begin errors++; $display("FAIL stable pulses: got %0b want 00", {step_pulse, invalid_pulse}); end
        drive_cycle(7'h3F);
    endtask

    task automatic test_count_seq();
        int s0;
        s0 = d_step_cnt;
        for (int i = 0; i < 18; i++) hold(tbl[i % 16], 5);
        checks += 4;
        if (d_step_cnt - s0 !== 17) begin errors++; $display("FAIL count_seq steps: got %0d want 17", d_step_cnt - s0); end
        if (count_out !== 8'h11) begin errors++; $display("FAIL count_seq count_out: got %0h want 11", count_out); end
        if (count_out !== 8'(m_count)) begin errors++; $display("FAIL count_seq model count: got %0h want %0h", count_out, m_count); end
        if (skip_err !== 1'b0) begin errors++; $display("FAIL count_seq skip_err: got %0b want 0", skip_err); end
    endtask

    task automatic test_glitch();
        int s0, i0;
        hold(7'h06, 5);
        s0 = d_step_cnt; i0 = d_inv_cnt;
        hold(7'h5B, 2);
        hold(7'h06, 5);
        checks += 4;
        if (digit_out !== 4'h1) begin errors++; $display("FAIL glitch digit_out: got %0h want 1", digit_out); end
        if (d_step_cnt - s0 !== 0) begin errors++; $display("FAIL glitch steps: got %0d want 0", d_step_cnt - s0); end
        if (d_inv_cnt - i0 !== 0) begin errors++; $display("FAIL glitch invalids: got %0d want 0", d_inv_cnt - i0); end
        if ({skip_err, invalid_err} !== 2'b00) begin errors++; $display("FAIL glitch errors: got %0b want 00", {skip_err, invalid_err}); end
    endtask

    task automatic test_skip();
        int s0;
        do_reset();
        hold(7'h4F, 5);
        checks++;
        if (skip_err !== 1'b0) begin errors++; $display("FAIL skip pre skip_err: got %0b want 0", skip_err); end
        s0 = d_step_cnt;
        hold(7'h07, 5);
        checks += 4;
        if (skip_err !== 1'b1) begin errors++; $display("FAIL skip skip_err: got %0b want 1", skip_err); end
        if (count_out[3:0] !== 4'h7) begin errors++; $display("FAIL skip count low: got %0h want 7", count_out[3:0]); end
        if (count_out !== 8'(m_count)) begin errors++; $display("FAIL skip count_out: got %0h want %0h", count_out, m_count); end
        if (d_step_cnt - s0 !== 0) begin errors++; $display("FAIL skip steps: got %0d want 0", d_step_cnt - s0); end
    endtask

    task automatic test_invalid();
        int s0, i0;
        do_reset();
        hold(7'h6D, 5);
        checks++;
        if (count_out !== 8'h05) begin errors++; $display("FAIL invalid pre count_out: got %0h want 05", count_out); end
        i0 = d_inv_cnt;
        hold(7'h55, 6);
        checks += 4;
        if (d_inv_cnt - i0 !== 1) begin errors++; $display("FAIL invalid pulses: got %0d want 1", d_inv_cnt - i0); end
        if (invalid_err !== 1'b1) begin errors++; $display("FAIL invalid invalid_err: got %0b want 1", invalid_err); end
        if (digit_out !== 4'h5) begin errors++; $display("FAIL invalid digit_out: got %0h want 5", digit_out); end
        if (count_out !== 8'h05) begin errors++; $display("FAIL invalid count_out: got %0h want 05", count_out); end
        s0 = d_step_cnt;
        hold(7'h7D, 5);
        checks += 2;
        if (d_step_cnt - s0 !== 1) begin errors++; $display("FAIL invalid post steps: got %0d want 1", d_step_cnt - s0); end
        if (count_out !== 8'h06) begin errors++; $display("FAIL invalid post count_out: got %0h want 06", count_out); end
    endtask

    task automatic test_wrap_and_reset();
        int s0;
        do_reset();
        hold(7'h71, 5);
        for (int i = 0; i < 240; i++) hold(tbl[i % 16], 5);
        checks++;
        if (count_out !== 8'hFF) begin errors++; $display("FAIL wrap pre count_out: got %0h want ff", count_out); end
        s0 = d_step_cnt;
        hold(7'h3F, 5);
        checks += 2;
        if (count_out !== 8'h00) begin errors++; $display("FAIL wrap count_out: got %0h want 00", count_out); end
        if (d_step_cnt - s0 !== 1) begin errors++; $display("FAIL wrap steps: got %0d want 1", d_step_cnt - s0); end
        // make both sticky flags set before the mid-run reset
        hold(7'h00, 5);
        hold(7'h6D, 5);
        checks++;
        if ({skip_err, invalid_err} !== 2'b11) begin errors++; $display("FAIL wrap sticky set: got %0b want 11", {skip_err, invalid_err}); end
        hold(7'h06, 2);
        do_reset();
        checks += 4;
        if ({skip_err, invalid_err} !== 2'b00) begin errors++; $display("FAIL midreset sticky: got %0b want 00", {skip_err, invalid_err}); end
        if (digit_valid !== 1'b0) begin errors++; $display("FAIL midreset digit_valid: got %0b want 0", digit_valid); end
        if (count_out !== 8'h00) begin errors++; $display("FAIL midreset count_out: got %0h want 00", count_out); end
        if (digit_out !== 4'h0) begin errors++; $display("FAIL midreset digit_out: got %0h want 0", digit_out); end
        hold(7'h06, S);
        checks++;
        if (digit_valid !== 1'b0) begin errors++; $display("FAIL midreset early accept: got %0b want 0", digit_valid); end
        drive_cycle(7'h06);
        checks += 2;
        if (digit_valid !== 1'b1) begin errors++; $display("FAIL midreset accept valid: got %0b want 1", digit_valid); end
        if (digit_out !== 4'h1) begin errors++; $display("FAIL midreset accept digit: got %0h want 1", digit_out); end
    endtask

    task automatic test_random();
        logic [6:0] pat;
        int         r;
        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            r = int'($urandom_range(0, 99));
            if (r < 65)      pat = tbl[(m_digit + 1) % 16];
            else if (r < 85) pat = tbl[$urandom_range(0, 15)];
            else             pat = 7'($urandom);
            hold(pat, int'($urandom_range(1, 7)));
            checks += 7;
            if (digit_out !== 4'(m_digit)) begin errors++; $display("FAIL rand digit_out seg%0d: got %0h want %0h", seg, digit_out, m_digit); end
            if (digit_valid !== 1'(m_valid)) begin errors++; $display("FAIL rand digit_valid seg%0d: got %0b want %0d", seg, digit_valid, m_valid); end
            if (count_out !== 8'(m_count)) begin errors++; $display("FAIL rand count_out seg%0d: got %0h want %0h", seg, count_out, m_count); end
            if (step_pulse !== 1'(m_step)) begin errors++; $display("FAIL rand step_pulse seg%0d: got %0b want %0d", seg, step_pulse, m_step); end
            if (invalid_pulse !== 1'(m_inv)) begin errors++; $display("FAIL rand invalid_pulse seg%0d: got %0b want %0d", seg, invalid_pulse, m_inv); end
            if (skip_err !== 1'(m_skip)) begin errors++; $display("FAIL rand skip_err seg%0d: got %0b want %0d", seg, skip_err, m_skip); end
            if (invalid_err !== 1'(m_inverr)) begin errors++; $display("FAIL rand invalid_err seg%0d: got %0b want %0d", seg, invalid_err, m_inverr); end
        end
        checks += 2;
        if (d_step_cnt !== m_step_cnt) begin errors++; $display("FAIL total step pulses: got %0d want %0d", d_step_cnt, m_step_cnt); end
        if (d_inv_cnt !== m_inv_cnt) begin errors++; $display("FAIL total invalid pulses: got %0d want %0d", d_inv_cnt, m_inv_cnt); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stable_digit();
        test_count_seq();
        test_glitch();
        test_skip();
        test_invalid();
        test_wrap_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
